// File: rtl/aes_stream_wrap_if.sv
// Stream bundle for aes_stream_wrap: 32-bit word input stream (s_*) and
// 32-bit result output stream (m_*), both valid/ready.
interface aes_stream_wrap_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  // Wrapper side: consumes the input stream, produces the output stream.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  // Environment side: produces input words, consumes result words.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/aes_stream_wrap.sv
// Word-serial front end for the AES loopback core. Collects key and text as
// eight 32-bit words, strobes the core, waits for completion under a
// watchdog, and returns the 128-bit result as four 32-bit words.
module aes_stream_wrap #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic                clk,
  input  logic                rst,
  aes_stream_wrap_if.slave    io,
  output logic                core_kld,
  output logic [127:0]        core_key,
  output logic [127:0]        core_text,
  input  logic                core_done,
  input  logic [127:0]        core_text_out,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [2:0]        in_idx_q, in_idx_d;
  logic [1:0]        out_idx_q, out_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0][31:0]  key_q, key_d;
  logic [3:0][31:0]  text_q, text_d;
  logic [3:0][31:0]  res_q, res_d;
  logic              err_q, err_d;

  // Word 0 is the most significant word, so stream index n maps to slot 3-n.
  logic [1:0]        in_slot;
  logic [1:0]        out_slot;

  assign in_slot  = 2'd3 - in_idx_q[1:0];
  assign out_slot = 2'd3 - out_idx_q;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  // NOTE: the key/text/result registers are reset as well, because the core
  // inputs and m_data must come out of reset at a known zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      text_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      text_q    <= text_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath update for the LOAD/START/WAIT/DRAIN sequence.
  // NOTE: every variable gets a hold default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    text_d    = text_q;
    res_d     = res_q;
    err_d     = err_q;

    unique case (state_q)
      ST_LOAD: begin
        // s_ready is high throughout LOAD, so s_valid alone is a handshake.
        if (io.s_valid) begin
          if (in_idx_q[2]) begin
            text_d[in_slot] = io.s_data;
          end else begin
            key_d[in_slot] = io.s_data;
          end
          // A new job starts clean: its first word drops the sticky error.
          if (in_idx_q == 3'd0) begin
            err_d = 1'b0;
          end
          in_idx_d = in_idx_q + 3'd1;
          if (in_idx_q == 3'd7) begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (core_done) begin
          res_d   = core_text_out;
          state_d = ST_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_DRAIN: begin
        if (io.m_ready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'd3) begin
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no input reaches them
  // combinationally.
  always_comb begin
    io.s_ready  = (state_q == ST_LOAD);
    io.m_valid  = (state_q == ST_DRAIN);
    io.m_data   = (state_q == ST_DRAIN) ? res_q[out_slot] : 32'd0;
    io.m_last   = (state_q == ST_DRAIN) && (out_idx_q == 2'd3);
    core_kld    = (state_q == ST_START);
    busy        = (state_q == ST_START) || (state_q == ST_WAIT);
    core_key    = key_q;
    core_text   = text_q;
    timeout_err = err_q;
  end

endmodule

// File: tb/tb_aes_stream_wrap.sv
// Directed/randomized bench for aes_stream_wrap. A behavioural loopback core
// returns the loaded text after a chosen latency (or never); expected words,
// latencies and error flags are derived from the job-level rules.
module tb_aes_stream_wrap;

  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_kld;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         busy;
  logic         timeout_err;

  aes_stream_wrap_if io ();

  aes_stream_wrap #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .io            (io.slave),
    .core_kld      (core_kld),
    .core_key      (core_key),
    .core_text     (core_text),
    .core_done     (core_done),
    .core_text_out (core_text_out),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial forever #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_key, exp_text;
  bit           pending, core_never, stray_req, err_model;
  int           wait_k, core_lat, kld_count;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then act as the core for the cycle just begun.
  task automatic tick();
    @(posedge clk);
    #1;
    core_done     = 1'b0;
    core_text_out = {$urandom, $urandom, $urandom, $urandom};
    if (stray_req) begin
      core_done = 1'b1;
      stray_req = 1'b0;
    end
    if (pending) begin
      wait_k++;
      check("core_key_stable", core_key, exp_key);
      check("core_text_stable", core_text, exp_text);
      if (!core_never && wait_k == core_lat) begin
        core_done     = 1'b1;
        core_text_out = exp_text;
        pending       = 1'b0;
      end else if (wait_k >= TO) begin
        pending = 1'b0;
      end
    end
    if (core_kld === 1'b1) begin
      kld_count++;
      check("kld_key", core_key, exp_key);
      check("kld_text", core_text, exp_text);
      pending = 1'b1;
      wait_k  = 0;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready", io.s_ready, 1);
    check("rst_m_valid", io.m_valid, 0);
    check("rst_m_data", io.m_data, 0);
    check("rst_m_last", io.m_last, 0);
    check("rst_core_kld", core_kld, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_text", core_text, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    pending     = 1'b0;
    stray_req   = 1'b0;
    core_done   = 1'b0;
    io.s_valid  = 1'b0;
    io.m_ready  = 1'b0;
    err_model   = 1'b0;
    #1;
    check_reset_vals();
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_s_ready", io.s_ready, 1);
      check("idle_m_valid", io.m_valid, 0);
      check("idle_busy", busy, 0);
      tick();
    end
  endtask

  // Present the eight words; leaves the bench in the START cycle.
  task automatic feed(input logic [127:0] key, input logic [127:0] text,
                      input bit bubbles, input int stray_at);
    logic [255:0] words;
    int           idx, guard, s_at;
    bit           hs;
    words = {key, text};
    idx   = 0;
    guard = 0;
    s_at  = stray_at;
    exp_key  = key;
    exp_text = text;
    while (idx < 8 && guard < 400) begin
      guard++;
      io.s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      io.s_data  = io.s_valid ? words[255-32*idx -: 32] : $urandom;
      check("load_s_ready", io.s_ready, 1);
      check("load_m_valid", io.m_valid, 0);
      if (idx == 0) check("err_before_job", timeout_err, err_model);
      hs = io.s_valid && io.s_ready;
      if (idx == s_at) begin
        stray_req = 1'b1;
        s_at      = -1;
      end
      tick();
      if (hs) begin
        idx++;
        if (idx == 1) begin
          err_model = 1'b0;
          check("err_cleared", timeout_err, 0);
        end
      end
    end
    if (idx < 8) check("feed_budget", idx, 8);
    io.s_valid = 1'b0;
  endtask

  // From START through WAIT; ends in DRAIN (done) or LOAD (timeout).
  task automatic wait_phase(input int lat, input bit never, input bit hold_sv, input int k0);
    int n;
    check("start_kld", core_kld, 1);
    check("start_busy", busy, 1);
    check("start_s_ready", io.s_ready, 0);
    check("kld_once", kld_count, k0 + 1);
    if (hold_sv) begin
      io.s_valid = 1'b1;
      io.s_data  = $urandom;
    end
    n = never ? TO : lat;
    for (int k = 1; k <= n; k++) begin
      tick();
      check("wait_busy", busy, 1);
      check("wait_kld", core_kld, 0);
      check("wait_s_ready", io.s_ready, 0);
      check("wait_m_valid", io.m_valid, 0);
      check("wait_err", timeout_err, 0);
      if (hold_sv) io.s_data = $urandom;
    end
    tick();
    if (never) begin
      io.s_valid = 1'b0;
      err_model  = 1'b1;
      check("to_err", timeout_err, 1);
      check("to_s_ready", io.s_ready, 1);
      check("to_m_valid", io.m_valid, 0);
      check("to_busy", busy, 0);
    end
  endtask

  task automatic drain(input logic [127:0] text, input int stall, input int nwords, input bit hold_sv);
    for (int w = 0; w < nwords; w++) begin
      for (int s = 0; s <= stall; s++) begin
        io.m_ready = (s == stall);
        check("out_m_valid", io.m_valid, 1);
        check("out_m_data", io.m_data, text[127-32*w -: 32]);
        check("out_m_last", io.m_last, (w == 3));
        check("out_s_ready", io.s_ready, 0);
        if (hold_sv) io.s_data = $urandom;
        tick();
      end
    end
    io.m_ready = 1'b0;
    if (nwords == 4) begin
      io.s_valid = 1'b0;
      check("end_s_ready", io.s_ready, 1);
      check("end_m_valid", io.m_valid, 0);
      check("end_busy", busy, 0);
      check("end_err", timeout_err, err_model);
    end
  endtask

  task automatic run_job(input logic [127:0] key, input logic [127:0] text, input int lat,
                         input bit never, input bit bubbles, input int stall,
                         input bit hold_sv, input int stray_at);
    int k0;
    core_lat   = lat;
    core_never = never;
    k0         = kld_count;
    feed(key, text, bubbles, stray_at);
    wait_phase(lat, never, hold_sv, k0);
    if (!never) drain(text, stall, 4, hold_sv);
    idle(2);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k, t;
    int           k0;
    rst           = 1'b1;
    io.s_valid    = 1'b0;
    io.s_data     = '0;
    io.m_ready    = 1'b0;
    core_done     = 1'b0;
    core_text_out = '0;
    pending       = 1'b0;
    stray_req     = 1'b0;
    err_model     = 1'b0;
    kld_count     = 0;
    #2;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Known-vector round trip, back-to-back, m_ready high.
    run_job(128'h000102030405060708090a0b0c0d0e0f,
            128'h00112233445566778899aabbccddeeff, 10, 0, 0, 0, 0, -1);

    // Input bubbles and 3-cycle stall on each output word.
    run_job(rnd128(), rnd128(), $urandom_range(1, 20), 0, 1, 3, 0, -1);

    // Core never completes, then the next job clears the error.
    run_job(rnd128(), rnd128(), 0, 1, 0, 0, 0, -1);
    idle(3);
    run_job(rnd128(), rnd128(), 7, 0, 1, 0, 0, -1);

    // Completion in the very cycle the watchdog would expire, and minimum latency.
    run_job(rnd128(), rnd128(), TO, 0, 0, 1, 0, -1);
    run_job(rnd128(), rnd128(), 1, 0, 0, 0, 0, -1);

    // Reset in the middle of WAIT, then a clean job.
    core_lat   = 30;
    core_never = 1'b0;
    k0         = kld_count;
    k = rnd128();
    t = rnd128();
    feed(k, t, 0, -1);
    for (int i = 0; i < 5; i++) tick();
    apply_reset();
    tick();
    idle(40);
    run_job(rnd128(), rnd128(), 4, 0, 0, 0, 0, -1);

    // Reset after the second output word, then a clean job.
    core_lat   = 5;
    core_never = 1'b0;
    k0         = kld_count;
    k = rnd128();
    t = rnd128();
    feed(k, t, 0, -1);
    wait_phase(5, 0, 0, k0);
    drain(t, 0, 2, 0);
    apply_reset();
    tick();
    idle(5);
    run_job(rnd128(), rnd128(), 3, 0, 0, 0, 0, -1);

    // Stray done while idle, then a job with stray done mid-load and
    // s_valid held high through WAIT and DRAIN.
    stray_req = 1'b1;
    tick();
    idle(3);
    run_job(rnd128(), rnd128(), 12, 0, 0, 0, 1, 3);

    // A few fully random jobs.
    for (int j = 0; j < 6; j++) begin
      run_job(rnd128(), rnd128(), $urandom_range(1, TO), 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_budget: observed no completion expected finish before time limit");
    $fatal(1, "simulation time budget exceeded");
  end

endmodule

// File: doc/aes_stream_wrap.md
# aes_stream_wrap

Word-serial front end for the AES encrypt/decrypt loopback core. It sits directly upstream and downstream of that core. It assembles a 128-bit key and a 128-bit text block from a 32-bit valid/ready input stream, then issues the load strobe and waits for the core's completion pulse. It captures the 128-bit result and returns it as four 32-bit words on a valid/ready output stream. A watchdog flags a core that never completes.

## Interface

Parameters:
- TIMEOUT_CYC, default 64: maximum number of WAIT cycles allowed before a timeout is declared.
- CNT_W, default 7: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted this cycle when s_valid && s_ready.
- s_data  in  32  input word. Words 0–3 are the key, MSW first (word0 = key[127:96]). Words 4–7 are the text, MSW first.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  32  result word, MSW first.
- m_last  out  1  high with the 4th output word.
- core_kld  out  1  one-cycle load strobe to the core; drives both its kld and key-load inputs.
- core_key  out  128  key to the core.
- core_text  out  128  text to the core.
- core_done  in  1  completion pulse from the core.
- core_text_out  in  128  core result, valid in the core_done cycle.
- busy  out  1  high in START and WAIT.
- timeout_err  out  1  sticky error flag.

## Operation

The block is a state machine with four states: LOAD, START, WAIT and DRAIN. Reset state is LOAD.

LOAD:
- s_ready=1.
- Each handshake writes s_data into key/text slot in_idx (3-bit) and increments in_idx.
- Handshake with in_idx=7 → in_idx wraps to 0, next state START.
- The first accepted word of a job (in_idx=0) clears timeout_err.

START:
- core_kld=1 for exactly this one cycle.
- Watchdog counter cleared.
- Next state WAIT.

WAIT:
- Counter increments each cycle.
- core_done=1 → capture core_text_out into the result register, next state DRAIN.
- Else, if counter == TIMEOUT_CYC-1 → set timeout_err, next state LOAD, nothing is output.
- core_done in the same cycle as the timeout condition: done wins. Result is captured, no error is flagged.

DRAIN:
- m_valid=1; m_data = result word out_idx (word0 = result[127:96]).
- m_last = (out_idx==3).
- On a handshake out_idx increments; after the handshake with m_last, out_idx→0 and next state LOAD.

Other rules:
- core_key and core_text are driven straight from the assembly registers. They are written only in LOAD, so they stay stable from START through WAIT.
- core_done outside WAIT is ignored.
- s_ready=0 in START, WAIT and DRAIN. Input is not accepted until the drain completes or a timeout occurs.

## Timing

- Reset values: s_ready=1 (LOAD), m_valid=0, m_data=0, m_last=0, core_kld=0, core_key=0, core_text=0, busy=0, timeout_err=0, all indices and counters 0.
- Reset mid-operation (any state) aborts immediately: the partial job and result are discarded and no m_valid follows.
- 8th input handshake at cycle N → START (core_kld=1) at N+1 → WAIT from N+2.
- core_done seen at cycle D → m_valid=1 at D+1. With m_ready held high, the words appear on D+1..D+4 and s_ready=1 at D+5.
- m_data and m_last are held stable while m_valid && !m_ready.
- Timeout: with no core_done, timeout_err rises and s_ready=1 in the cycle after the (TIMEOUT_CYC)-th WAIT cycle, i.e. cycle N+2+TIMEOUT_CYC.
- All outputs are registered or decoded from registered state. There are no combinational paths from s_valid, m_ready or core_done to any output.

## Test plan

- **Round trip through the real core.** Stimulus: key 00010203 04050607 08090a0b 0c0d0e0f, text 00112233 44556677 8899aabb ccddeeff, back-to-back. Required response: exactly one core_kld pulse; output 00112233, 44556677, 8899aabb, ccddeeff with m_last on the 4th word; timeout_err=0.
- **Input bubbles and output backpressure.** Stimulus: s_valid toggled randomly, m_ready low for 3 cycles at each word. Required response: same four words, each held stable while stalled; no word duplicated or dropped; s_ready=0 until the final handshake.
- **Timeout.** Stimulus: core model that never pulses core_done, TIMEOUT_CYC=64. Required response: timeout_err=1 at N+66, s_ready=1, no m_valid. The next job's first accepted word clears timeout_err.
- **Done on the boundary.** Stimulus: core model asserts core_done in the exact cycle the counter reaches TIMEOUT_CYC-1. Required response: result is drained, timeout_err stays 0.
- **Reset mid-WAIT and mid-DRAIN.** Stimulus: rst pulsed mid-WAIT, then separately after the 2nd output word. Required response: all outputs at reset values. A following full job produces the correct four words starting from word0.
- **Stray done and early input.** Stimulus: core_done pulsed in LOAD; s_valid held high through WAIT. Required response: no output and no state change from the stray pulse; no input accepted until LOAD.
